// File: rtl/serial_compare_scheduler.sv
// Round-robin front end that time-shares one MSB-first serial comparator among
// N_REQ parallel-word requesters and returns each verdict tagged with its requester id.
module serial_compare_scheduler #(
    parameter int WIDTH = 8,
    parameter int N_REQ = 4,
    localparam int ID_W = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [N_REQ-1:0]       req_valid,
    input  logic [N_REQ*WIDTH-1:0] req_a,
    input  logic [N_REQ*WIDTH-1:0] req_b,
    output logic [N_REQ-1:0]       req_ready,
    output logic                   cmp_rst,
    output logic                   cmp_a,
    output logic                   cmp_b,
    input  logic                   cmp_less,
    input  logic                   cmp_eq,
    input  logic                   cmp_greater,
    output logic                   res_valid,
    input  logic                   res_ready,
    output logic [ID_W-1:0]        res_id,
    output logic                   res_less,
    output logic                   res_eq,
    output logic                   res_greater
);

    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [ID_W:0] NREQ_W = (ID_W+1)'(N_REQ);

    typedef enum logic [1:0] {
        S_IDLE,
        S_CLEAR,
        S_SHIFT,
        S_RESULT
    } state_t;

    state_t r_state;
    state_t w_state_next;

    logic [ID_W-1:0]  r_rr_ptr;
    logic [CNT_W-1:0] r_bit_cnt;
    logic [WIDTH-1:0] r_a_lat;
    logic [WIDTH-1:0] r_b_lat;
    logic [ID_W-1:0]  r_id_lat;

    logic [WIDTH-1:0] w_a_arr [N_REQ];
    logic [WIDTH-1:0] w_b_arr [N_REQ];
    logic [ID_W:0]    w_rot_sum [N_REQ];
    logic [ID_W:0]    w_rot_full [N_REQ];
    logic [ID_W-1:0]  w_rot_idx [N_REQ];
    logic [N_REQ-1:0] w_rot_valid;
    logic [ID_W-1:0]  w_grant_id;
    logic [ID_W-1:0]  w_next_ptr;
    logic             w_found;
    logic             w_hs;

    // Slot gi of the rotated view is requester (rr_ptr + gi) mod N_REQ.
    genvar gi;
    generate
        for (gi = 0; gi < N_REQ; gi++) begin : g_slot
            assign w_a_arr[gi]     = req_a[gi*WIDTH +: WIDTH];
            assign w_b_arr[gi]     = req_b[gi*WIDTH +: WIDTH];
            assign w_rot_sum[gi]   = {1'b0, r_rr_ptr} + (ID_W+1)'(gi);
            assign w_rot_full[gi]  = (w_rot_sum[gi] >= NREQ_W) ? (w_rot_sum[gi] - NREQ_W)
                                                               : w_rot_sum[gi];
            assign w_rot_idx[gi]   = w_rot_full[gi][ID_W-1:0];
            assign w_rot_valid[gi] = req_valid[w_rot_idx[gi]];
        end
    endgenerate

    always_comb begin
        w_grant_id = '0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            if (w_rot_valid[k]) begin
                w_grant_id = w_rot_idx[k];
            end
        end
    end

    assign w_found    = |req_valid;
    assign w_hs       = (r_state == S_IDLE) && !rst && w_found;
    assign w_next_ptr = (w_grant_id == ID_W'(N_REQ - 1)) ? '0 : (w_grant_id + ID_W'(1));

    always_comb begin
        req_ready = '0;
        if (w_hs) begin
            req_ready[w_grant_id] = 1'b1;
        end
    end

    always_comb begin
        w_state_next = r_state;
        cmp_rst      = rst;
        cmp_a        = 1'b0;
        cmp_b        = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_hs) w_state_next = S_CLEAR;
            end
            S_CLEAR: begin
                cmp_rst      = 1'b1;
                w_state_next = S_SHIFT;
            end
            S_SHIFT: begin
                cmp_a = r_a_lat[r_bit_cnt];
                cmp_b = r_b_lat[r_bit_cnt];
                if (r_bit_cnt == '0) w_state_next = S_RESULT;
            end
            S_RESULT: begin
                if (res_ready) w_state_next = S_IDLE;
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rr_ptr    <= '0;
            r_bit_cnt   <= '0;
            r_a_lat     <= '0;
            r_b_lat     <= '0;
            r_id_lat    <= '0;
            res_valid   <= 1'b0;
            res_id      <= '0;
            res_less    <= 1'b0;
            res_eq      <= 1'b0;
            res_greater <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_hs) begin
                        r_a_lat  <= w_a_arr[w_grant_id];
                        r_b_lat  <= w_b_arr[w_grant_id];
                        r_id_lat <= w_grant_id;
                        r_rr_ptr <= w_next_ptr;
                    end
                end
                S_CLEAR: begin
                    r_bit_cnt <= CNT_W'(WIDTH - 1);
                end
                S_SHIFT: begin
                    if (r_bit_cnt == '0) begin
                        // Comparator outputs already include the LSB pair on this cycle.
                        res_less    <= cmp_less;
                        res_eq      <= cmp_eq;
                        res_greater <= cmp_greater;
                        res_id      <= r_id_lat;
                        res_valid   <= 1'b1;
                    end else begin
                        r_bit_cnt <= r_bit_cnt - CNT_W'(1);
                    end
                end
                S_RESULT: begin
                    if (res_ready) res_valid <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && (r_state == S_SHIFT) && (r_bit_cnt == '0)) begin
            assert ($onehot({cmp_less, cmp_eq, cmp_greater}));
        end
    end

endmodule

// File: tb/tb_serial_compare_scheduler.sv
// Directed bench for serial_compare_scheduler with a behavioural serial comparator.
module tb_serial_compare_scheduler;

    localparam int W = 8;
    localparam int N = 4;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic [N-1:0]   req_valid = '0;
    logic [N*W-1:0] req_a = '0;
    logic [N*W-1:0] req_b = '0;
    logic [N-1:0]   req_ready;
    logic           cmp_rst, cmp_a, cmp_b;
    logic           cmp_less, cmp_eq, cmp_greater;
    logic           res_valid;
    logic           res_ready = 1'b0;
    logic [1:0]     res_id;
    logic           res_less, res_eq, res_greater;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    serial_compare_scheduler #(.WIDTH(W), .N_REQ(N)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_a(req_a), .req_b(req_b), .req_ready(req_ready),
        .cmp_rst(cmp_rst), .cmp_a(cmp_a), .cmp_b(cmp_b),
        .cmp_less(cmp_less), .cmp_eq(cmp_eq), .cmp_greater(cmp_greater),
        .res_valid(res_valid), .res_ready(res_ready), .res_id(res_id),
        .res_less(res_less), .res_eq(res_eq), .res_greater(res_greater)
    );

    // MSB-first comparator: 0 = equal so far, 1 = a<b decided, 2 = a>b decided.
    logic [1:0] m_cs = 2'd0;
    always_ff @(posedge clk) begin
        if (cmp_rst) m_cs <= 2'd0;
        else if (m_cs == 2'd0) m_cs <= (!cmp_a && cmp_b) ? 2'd1 : ((cmp_a && !cmp_b) ? 2'd2 : 2'd0);
    end
    assign cmp_less    = (m_cs == 2'd1) || (m_cs == 2'd0 && !cmp_a && cmp_b);
    assign cmp_greater = (m_cs == 2'd2) || (m_cs == 2'd0 && cmp_a && !cmp_b);
    assign cmp_eq      = (m_cs == 2'd0) && (cmp_a == cmp_b);

    typedef struct {
        int         id;
        logic [7:0] a;
        logic [7:0] b;
        logic [2:0] exp;   // {less, eq, greater}
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic wait_grant(input int id, input string tag);
        int cnt;
        cnt = 0;
        #1;
        while (!req_ready[id] && cnt < 20) begin
            @(negedge clk);
            #1;
            cnt++;
        end
        check({tag, "_grant"}, 32'(req_ready), 32'(4'b0001 << id));
    endtask

    task automatic run_vec(input vec_t v, input int n);
        int k;
        logic [7:0] sa, sb;
        string tag;
        tag = $sformatf("vec%0d", n);
        @(negedge clk);
        req_valid = '0;
        req_valid[v.id] = 1'b1;
        req_a[v.id*W +: W] = v.a;
        req_b[v.id*W +: W] = v.b;
        wait_grant(v.id, tag);
        @(posedge clk);
        #1 req_valid = '0;
        k = 0; sa = '0; sb = '0;
        while (!res_valid && k < 30) begin
            @(negedge clk);
            k++;
            if (k == 1) check({tag, "_clear_cmp_rst"}, 32'(cmp_rst), 32'd1);
            if (k >= 2 && k <= 9) begin
                sa = {sa[6:0], cmp_a};
                sb = {sb[6:0], cmp_b};
            end
        end
        check({tag, "_latency"}, 32'(k), 32'd10);
        check({tag, "_cmp_a_bits"}, 32'(sa), 32'(v.a));
        check({tag, "_cmp_b_bits"}, 32'(sb), 32'(v.b));
        check({tag, "_res_id"}, 32'(res_id), 32'(v.id));
        check({tag, "_verdict"}, 32'({res_less, res_eq, res_greater}), 32'(v.exp));
        $display("vec%0d id=%0d a=%02h b=%02h verdict=%03b latency=%0d", n, v.id, v.a, v.b,
                 {res_less, res_eq, res_greater}, k);
        res_ready = 1'b1;
        @(posedge clk);
        #1 res_ready = 1'b0;
        @(negedge clk);
        check({tag, "_res_drop"}, 32'(res_valid), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs[7];
        int   g, r, cyc, k, hits;
        int   gord[5];
        int   rord[5];
        int   exp_ord[5];
        logic [2:0] exp3[4];

        vecs[0] = '{0, 8'hA5, 8'hA5, 3'b010};
        vecs[1] = '{2, 8'h80, 8'h7F, 3'b001};
        vecs[2] = '{1, 8'h01, 8'h02, 3'b100};
        vecs[3] = '{3, 8'hC3, 8'h3C, 3'b001};
        vecs[4] = '{0, 8'h00, 8'hFF, 3'b100};
        vecs[5] = '{1, 8'hFF, 8'hFF, 3'b010};
        vecs[6] = '{3, 8'hFF, 8'hFE, 3'b001};
        exp_ord = '{0, 1, 2, 3, 0};
        exp3    = '{3'b100, 3'b100, 3'b010, 3'b001};

        // Reset state
        repeat (2) @(negedge clk);
        check("rst_req_ready", 32'(req_ready), 32'd0);
        check("rst_res_valid", 32'(res_valid), 32'd0);
        check("rst_cmp_rst", 32'(cmp_rst), 32'd1);
        check("rst_cmp_ab", 32'({cmp_a, cmp_b}), 32'd0);
        check("rst_res_fields", 32'({res_id, res_less, res_eq, res_greater}), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        check("idle_cmp_rst", 32'(cmp_rst), 32'd0);
        check("idle_req_ready", 32'(req_ready), 32'd0);

        // Table-driven single requests
        for (int i = 0; i < 7; i++) run_vec(vecs[i], i);

        // All requesters valid from reset: strict round-robin order
        @(negedge clk);
        rst = 1'b1;
        req_valid = 4'hF;
        req_a = {8'd3, 8'd2, 8'd1, 8'd0};
        req_b = {4{8'd2}};
        res_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        g = 0; r = 0; cyc = 0;
        while (r < 5 && cyc < 200) begin
            #1;
            if (req_ready != '0 && g < 5) begin
                check($sformatf("rr_onehot%0d", g), 32'($countones(req_ready)), 32'd1);
                for (int i = 0; i < N; i++) if (req_ready[i]) gord[g] = i;
                g++;
            end
            if (res_valid) begin
                rord[r] = int'(res_id);
                check($sformatf("rr_verdict%0d", r), 32'({res_less, res_eq, res_greater}),
                      32'(exp3[res_id]));
                $display("rr result %0d id=%0d verdict=%03b", r, res_id, {res_less, res_eq, res_greater});
                r++;
                if (r == 5) req_valid = '0;
            end
            @(negedge clk);
            cyc++;
        end
        res_ready = 1'b0;
        check("rr_grant_count", 32'(g), 32'd5);
        check("rr_result_count", 32'(r), 32'd5);
        for (int i = 0; i < 5; i++) begin
            check($sformatf("rr_grant_order%0d", i), 32'(gord[i]), 32'(exp_ord[i]));
            check($sformatf("rr_result_id%0d", i), 32'(rord[i]), 32'(exp_ord[i]));
        end

        // Result back-pressure: outputs hold, no grant until after res_ready
        @(negedge clk);
        req_valid = 4'b1000;
        req_a[31:24] = 8'h10;
        req_b[31:24] = 8'h20;
        wait_grant(3, "stall");
        @(posedge clk);
        #1 req_valid = 4'b0010;
        req_a[15:8] = 8'h55;
        req_b[15:8] = 8'h55;
        k = 0;
        while (!res_valid && k < 30) begin
            @(negedge clk);
            k++;
        end
        for (int s = 0; s < 5; s++) begin
            if (s > 0) @(negedge clk);
            check($sformatf("stall_hold%0d", s),
                  32'({res_valid, res_id, res_less, res_eq, res_greater}), 32'({1'b1, 2'd3, 3'b100}));
            check($sformatf("stall_no_grant%0d", s), 32'(req_ready), 32'd0);
            $display("stall cycle %0d res_valid=%0b req_ready=%04b", s, res_valid, req_ready);
        end
        res_ready = 1'b1;
        @(posedge clk);
        #1 res_ready = 1'b0;
        @(negedge clk);
        check("stall_release_valid", 32'(res_valid), 32'd0);
        check("stall_release_grant", 32'(req_ready), 32'(4'b0010));
        req_valid = '0;

        // Reset pulse during SHIFT bit 3 aborts and restarts round-robin at 0
        @(negedge clk);
        req_valid = 4'b0100;
        req_a[23:16] = 8'hF0;
        req_b[23:16] = 8'h0F;
        wait_grant(2, "abort");
        @(posedge clk);
        #1 req_valid = '0;
        for (int i = 1; i <= 6; i++) @(negedge clk);
        rst = 1'b1;
        #1 check("abort_cmp_rst_comb", 32'(cmp_rst), 32'd1);
        @(negedge clk);
        check("abort_res_valid", 32'(res_valid), 32'd0);
        check("abort_cmp_rst", 32'(cmp_rst), 32'd1);
        check("abort_req_ready", 32'(req_ready), 32'd0);
        rst = 1'b0;
        hits = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (res_valid) hits++;
        end
        check("abort_no_result", 32'(hits), 32'd0);
        req_valid = 4'b1010;
        #1 check("abort_ptr_reset_grant", 32'(req_ready), 32'(4'b0010));
        $display("abort: post-reset grant=%04b", req_ready);
        req_valid = '0;

        repeat (2) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
